lsq_ret_buf: RTL and testbench



---
 rtl/lsq_ret_buf_pkg.sv | 26 ++
 rtl/lsq_ret_buf_if.sv | 48 ++++
 rtl/lsq_ret_buf_ptr.sv | 44 ++++
 rtl/lsq_ret_buf.sv | 138 +++++++++++++
 tb/tb_lsq_ret_buf.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lsq_ret_buf_pkg.sv
// Shared types and constants for the LSQ retire-bundle queue.
// Supplies a default for `LSQSHARE_WIDTH when the surrounding build has not defined it.
`ifndef LSQSHARE_WIDTH
`define LSQSHARE_WIDTH 16
`endif

package lsq_ret_buf_pkg;
    localparam int RET_SLOTS       = 6;
    localparam int EXBITS_PER_SLOT = 4;
    localparam int II_SLOT_W       = 4;
    localparam int II_W            = 6;
    localparam int SHR_DEF_W       = `LSQSHARE_WIDTH;

    // One retire bundle as held in the queue.
    typedef struct packed {
        logic [RET_SLOTS-1:0]                 ret_mask;
        logic [RET_SLOTS-1:0]                 ld_confl;
        logic [RET_SLOTS-1:0]                 wait_confl;
        logic [RET_SLOTS-1:0]                 excpt;
        logic [RET_SLOTS*EXBITS_PER_SLOT-1:0] exbits;
        logic                                 thread;
        logic [II_W-1:0]                      II;
        logic [RET_SLOTS*II_SLOT_W-1:0]       II_slots;
        logic [SHR_DEF_W-1:0]                 shr;
    } ret_bundle_t;
endpackage

// File: rtl/lsq_ret_buf_if.sv
// Bundle-in / head-out bus of the retire-bundle queue.
// slave: the queue itself; master: the producer/decision-stage side.
interface lsq_ret_buf_if import lsq_ret_buf_pkg::*; #(
    parameter int SHR_W = SHR_DEF_W
);
    logic                                 in_valid;
    logic                                 in_ready;
    logic [RET_SLOTS-1:0]                 in_ret_mask;
    logic [RET_SLOTS-1:0]                 in_ld_confl;
    logic [RET_SLOTS-1:0]                 in_wait_confl;
    logic [RET_SLOTS-1:0]                 in_excpt;
    logic [RET_SLOTS*EXBITS_PER_SLOT-1:0] in_exbits;
    logic                                 in_thread;
    logic [II_W-1:0]                      in_II;
    logic [RET_SLOTS*II_SLOT_W-1:0]       in_II_slots;
    logic [SHR_W-1:0]                     in_shr;

    logic [RET_SLOTS-1:0]                 dataB_ret_mask;
    logic [RET_SLOTS-1:0]                 dataB_ld_confl;
    logic [RET_SLOTS-1:0]                 dataB_wait_confl;
    logic [RET_SLOTS-1:0]                 dataB_excpt;
    logic [RET_SLOTS*EXBITS_PER_SLOT-1:0] dataB_exbits;
    logic                                 dataB_thread;
    logic [II_W-1:0]                      dataB_II;
    logic [II_SLOT_W-1:0]                 dataB_II0, dataB_II1, dataB_II2;
    logic [II_SLOT_W-1:0]                 dataB_II3, dataB_II4, dataB_II5;
    logic [SHR_W-1:0]                     dataB_data_shr;
    logic                                 dataB_ready;
    logic                                 dataB_enOut;

    modport master (
        output in_valid, in_ret_mask, in_ld_confl, in_wait_confl, in_excpt,
               in_exbits, in_thread, in_II, in_II_slots, in_shr, dataB_enOut,
        input  in_ready, dataB_ret_mask, dataB_ld_confl, dataB_wait_confl,
               dataB_excpt, dataB_exbits, dataB_thread, dataB_II, dataB_II0,
               dataB_II1, dataB_II2, dataB_II3, dataB_II4, dataB_II5,
               dataB_data_shr, dataB_ready
    );

    modport slave (
        input  in_valid, in_ret_mask, in_ld_confl, in_wait_confl, in_excpt,
               in_exbits, in_thread, in_II, in_II_slots, in_shr, dataB_enOut,
        output in_ready, dataB_ret_mask, dataB_ld_confl, dataB_wait_confl,
               dataB_excpt, dataB_exbits, dataB_thread, dataB_II, dataB_II0,
               dataB_II1, dataB_II2, dataB_II3, dataB_II4, dataB_II5,
               dataB_data_shr, dataB_ready
    );
endinterface

// File: rtl/lsq_ret_buf_ptr.sv
// Read/write pointer pair with wrap bit; derives full, empty and occupancy.
module lsq_ret_buf_ptr #(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_inc,
    input  logic             rd_inc,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic             full,
    output logic             empty,
    output logic [PTR_W-1:0] count
);
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    // Next pointer values; plain binary overflow handles the wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_inc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_inc) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                    (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
    assign count  = wr_ptr_q - rd_ptr_q;
endmodule

// File: rtl/lsq_ret_buf.sv
// Retire-bundle queue in front of the LSQ retire-decision stage.
// Holds bundles in II order, presents the head, drops a thread's bundles on exception.
// Optional same-cycle bypass of an empty queue: define LSQ_RETBUF_BYPASS_EN.
module lsq_ret_buf import lsq_ret_buf_pkg::*; #(
    parameter int DEPTH = 8,
    parameter int SHR_W = SHR_DEF_W
) (
    input  logic                  clk,
    input  logic                  rst,
    lsq_ret_buf_if.slave          bus,
    input  logic                  except,
    input  logic                  except_thread,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = PTR_W - 1;

    ret_bundle_t      mem_q [DEPTH];
    ret_bundle_t      mem_d [DEPTH];
    logic [DEPTH-1:0] entry_vld_q, entry_vld_d;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic             full, empty;
    ret_bundle_t      in_b, head_b, out_b;
    logic             push_fire, wr_en, pop_fire, hole_skip, rd_inc;
    logic             flush_in, head_flush, stored_rdy, out_rdy;
`ifdef LSQ_RETBUF_BYPASS_EN
    logic             byp_take, byp_consume;
`endif

    lsq_ret_buf_ptr #(.DEPTH(DEPTH)) u_ptr (
        .clk    (clk),
        .rst    (rst),
        .wr_inc (wr_en),
        .rd_inc (rd_inc),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    assign wr_idx = wr_ptr[IDX_W-1:0];
    assign rd_idx = rd_ptr[IDX_W-1:0];
    assign head_b = mem_q[rd_idx];

    // Pack the incoming bus fields into one bundle.
    always_comb begin
        in_b            = '0;
        in_b.ret_mask   = bus.in_ret_mask;
        in_b.ld_confl   = bus.in_ld_confl;
        in_b.wait_confl = bus.in_wait_confl;
        in_b.excpt      = bus.in_excpt;
        in_b.exbits     = bus.in_exbits;
        in_b.thread     = bus.in_thread;
        in_b.II         = bus.in_II;
        in_b.II_slots   = bus.in_II_slots;
        in_b.shr        = SHR_DEF_W'(bus.in_shr);
    end

    // Handshake decisions; a flush beats any same-cycle push or pop of that thread.
    always_comb begin
        flush_in   = except && (bus.in_thread == except_thread);
        head_flush = except && (head_b.thread == except_thread);
        stored_rdy = !empty && entry_vld_q[rd_idx];
        push_fire  = bus.in_valid && !full;
        pop_fire   = bus.dataB_enOut && stored_rdy && !head_flush;
        hole_skip  = !empty && !entry_vld_q[rd_idx];
        rd_inc     = pop_fire || hole_skip;
        wr_en      = push_fire && !flush_in;
`ifdef LSQ_RETBUF_BYPASS_EN
        // Only holes (or nothing) stored: the offered bundle can go straight out.
        byp_take    = push_fire && !(|entry_vld_q) && !flush_in;
        byp_consume = byp_take && bus.dataB_enOut;
        if (byp_consume) wr_en = 1'b0;
`endif
    end

    // Storage and valid-bit updates: pop clear, thread flush, then the new write.
    always_comb begin
        mem_d       = mem_q;
        entry_vld_d = entry_vld_q;
        if (pop_fire) entry_vld_d[rd_idx] = 1'b0;
        if (except) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_q[i].thread == except_thread) entry_vld_d[i] = 1'b0;
            end
        end
        if (wr_en) begin
            mem_d[wr_idx]       = in_b;
            entry_vld_d[wr_idx] = 1'b1;
        end
    end

    // Valid bits are control state and reset; payload storage does not.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) entry_vld_q <= '0;
        else      entry_vld_q <= entry_vld_d;
    end

    // Payload storage.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end

    // Head selection; fields read as zero whenever nothing is presented.
    always_comb begin
        out_b   = '0;
        out_rdy = 1'b0;
        if (stored_rdy) begin
            out_b   = head_b;
            out_rdy = 1'b1;
        end
`ifdef LSQ_RETBUF_BYPASS_EN
        else if (byp_take) begin
            out_b   = in_b;
            out_rdy = 1'b1;
        end
`endif
    end

    assign bus.in_ready         = !full;
    assign bus.dataB_ready      = out_rdy;
    assign bus.dataB_ret_mask   = out_b.ret_mask;
    assign bus.dataB_ld_confl   = out_b.ld_confl;
    assign bus.dataB_wait_confl = out_b.wait_confl;
    assign bus.dataB_excpt      = out_b.excpt;
    assign bus.dataB_exbits     = out_b.exbits;
    assign bus.dataB_thread     = out_b.thread;
    assign bus.dataB_II         = out_b.II;
    assign bus.dataB_II0        = out_b.II_slots[0*II_SLOT_W +: II_SLOT_W];
    assign bus.dataB_II1        = out_b.II_slots[1*II_SLOT_W +: II_SLOT_W];
    assign bus.dataB_II2        = out_b.II_slots[2*II_SLOT_W +: II_SLOT_W];
    assign bus.dataB_II3        = out_b.II_slots[3*II_SLOT_W +: II_SLOT_W];
    assign bus.dataB_II4        = out_b.II_slots[4*II_SLOT_W +: II_SLOT_W];
    assign bus.dataB_II5        = out_b.II_slots[5*II_SLOT_W +: II_SLOT_W];
    assign bus.dataB_data_shr   = SHR_W'(out_b.shr);
endmodule

// File: tb/tb_lsq_ret_buf.sv
// Self-checking bench for lsq_ret_buf (DEPTH=8); scoreboard of expected bundles.
// Bypass-only checks are included when LSQ_RETBUF_BYPASS_EN is defined.
module tb_lsq_ret_buf;
    import lsq_ret_buf_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       except = 1'b0;
    logic       except_thread = 1'b0;
    logic [3:0] count;

    lsq_ret_buf_if bif ();

    lsq_ret_buf #(.DEPTH(8), .SHR_W(SHR_DEF_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bif),
        .except        (except),
        .except_thread (except_thread),
        .count         (count)
    );

    always #5 clk = ~clk;

    int          n_run  = 0;
    int          n_fail = 0;
    ret_bundle_t sb_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ret_bundle_t make_b(input logic [5:0] ii, input logic th);
        ret_bundle_t b;
        b            = '0;
        b.ret_mask   = ii ^ 6'h2A;
        b.ld_confl   = ~ii;
        b.wait_confl = {ii[2:0], ii[5:3]};
        b.excpt      = ii & 6'h0F;
        b.exbits     = {ii[3:0], ~ii[3:0], ii[5:2], 4'hA, ii[3:0], 4'h5};
        b.thread     = th;
        b.II         = ii;
        for (int s = 0; s < 6; s++) b.II_slots[s*4 +: 4] = ii[3:0] + 4'(s);
        b.shr        = SHR_DEF_W'({ii, 10'h2D3});
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_b(input logic [5:0] ii, input logic th);
        ret_bundle_t b;
        b                 = make_b(ii, th);
        bif.in_ret_mask   = b.ret_mask;
        bif.in_ld_confl   = b.ld_confl;
        bif.in_wait_confl = b.wait_confl;
        bif.in_excpt      = b.excpt;
        bif.in_exbits     = b.exbits;
        bif.in_thread     = b.thread;
        bif.in_II         = b.II;
        bif.in_II_slots   = b.II_slots;
        bif.in_shr        = b.shr;
    endtask

    task automatic push(input logic [5:0] ii, input logic th);
        drive_b(ii, th);
        bif.in_valid = 1'b1;
        step();
        bif.in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        bif.dataB_enOut = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (count == 0) break;
            step();
        end
        bif.dataB_enOut = 1'b0;
        chk(tag, count, 0);
    endtask

    // Scoreboard: flush prune, accepted push, then head pop compare.
    always @(negedge clk) begin
        if (rst) begin
            if (except) begin
                ret_bundle_t keep [$];
                foreach (sb_q[i]) if (sb_q[i].thread != except_thread) keep.push_back(sb_q[i]);
                sb_q = keep;
            end
            if (bif.in_valid && bif.in_ready && !(except && bif.in_thread == except_thread))
                sb_q.push_back(make_b(bif.in_II, bif.in_thread));
            if (bif.dataB_ready && bif.dataB_enOut && !(except && bif.dataB_thread == except_thread)) begin
                chk("pop_has_expect", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    ret_bundle_t e;
                    e = sb_q.pop_front();
                    chk("pop_II", bif.dataB_II, e.II);
                    chk("pop_thread", bif.dataB_thread, e.thread);
                    chk("pop_masks", {bif.dataB_ret_mask, bif.dataB_ld_confl, bif.dataB_wait_confl, bif.dataB_excpt},
                        {e.ret_mask, e.ld_confl, e.wait_confl, e.excpt});
                    chk("pop_exbits", bif.dataB_exbits, e.exbits);
                    chk("pop_slots", {bif.dataB_II5, bif.dataB_II4, bif.dataB_II3, bif.dataB_II2, bif.dataB_II1, bif.dataB_II0},
                        e.II_slots);
                    chk("pop_shr", bif.dataB_data_shr, e.shr);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.in_valid    = 1'b0;
        bif.dataB_enOut = 1'b0;
        drive_b(6'h0, 1'b0);
        step();
        step();
        chk("rst0_ready", bif.dataB_ready, 0);
        chk("rst0_count", count, 0);
        chk("rst0_in_ready", bif.in_ready, 1);
        rst = 1'b1;
        step();

        // Reset mid-stream with 5 entries held
        for (int i = 0; i < 5; i++) push(6'(8'h20 + i), 1'b0);
        chk("hold5_count", count, 5);
        rst = 1'b0;
        #1;
        chk("midrst_ready", bif.dataB_ready, 0);
        chk("midrst_count", count, 0);
        chk("midrst_in_ready", bif.in_ready, 1);
        chk("midrst_II", bif.dataB_II, 0);
        sb_q.delete();
        step();
        rst = 1'b1;
        drive_b(6'h11, 1'b0);
        bif.in_valid = 1'b1;
        #1;
`ifndef LSQ_RETBUF_BYPASS_EN
        chk("lat_not_yet", bif.dataB_ready, 0);
`endif
        step();
        bif.in_valid = 1'b0;
        #1;
        chk("lat_ready", bif.dataB_ready, 1);
        chk("lat_II", bif.dataB_II, 6'h11);
        bif.dataB_enOut = 1'b1;
        step();
        bif.dataB_enOut = 1'b0;
        chk("after_pop_count", count, 0);

        // Fill to full, refuse a 9th
        for (int i = 0; i < 8; i++) push(6'(i), 1'b0);
        #1;
        chk("full_in_ready", bif.in_ready, 0);
        chk("full_count", count, 8);
        drive_b(6'h3F, 1'b0);
        bif.in_valid = 1'b1;
        step();
        bif.in_valid = 1'b0;
        chk("ninth_refused", count, 8);

        // Full: push + pop same cycle, push refused
        drive_b(6'h08, 1'b0);
        bif.in_valid    = 1'b1;
        bif.dataB_enOut = 1'b1;
        #1;
        chk("full_pp_in_ready", bif.in_ready, 0);
        step();
        bif.in_valid    = 1'b0;
        bif.dataB_enOut = 1'b0;
        chk("full_pp_count", count, 7);
        drain("drain_full");
        chk("sb_empty_1", sb_q.size(), 0);

        // Thread flush with a dropped same-thread push
        push(6'd1, 1'b0);
        push(6'd2, 1'b1);
        push(6'd3, 1'b0);
        except        = 1'b1;
        except_thread = 1'b0;
        drive_b(6'h15, 1'b0);
        bif.in_valid  = 1'b1;
        #1;
        chk("flush_in_ready", bif.in_ready, 1);
        step();
        except       = 1'b0;
        bif.in_valid = 1'b0;
        chk("flush_count", count, 3);
        chk("flush_hole_head", bif.dataB_ready, 0);
        step();
        chk("flush_skip_ready", bif.dataB_ready, 1);
        chk("flush_skip_II", bif.dataB_II, 2);
        bif.dataB_enOut = 1'b1;
        step();
        bif.dataB_enOut = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (count == 0) break;
            step();
        end
        chk("flush_drain_count", count, 0);
        chk("sb_empty_2", sb_q.size(), 0);

        // Pointer wrap with 20 push/pop pairs
        push(6'h20, 1'b1);
        bif.in_valid    = 1'b1;
        bif.dataB_enOut = 1'b1;
        for (int i = 1; i < 20; i++) begin
            drive_b(6'(8'h20 + i), 1'(i & 1));
            step();
            chk("wrap_count_le1", count <= 1, 1);
        end
        bif.in_valid = 1'b0;
        step();
        bif.dataB_enOut = 1'b0;
        chk("wrap_end_count", count, 0);
        chk("sb_empty_3", sb_q.size(), 0);

`ifdef LSQ_RETBUF_BYPASS_EN
        // Bypass on an empty buffer
        drive_b(6'h05, 1'b0);
        bif.in_valid    = 1'b1;
        bif.dataB_enOut = 1'b1;
        #1;
        chk("byp_ready", bif.dataB_ready, 1);
        chk("byp_II", bif.dataB_II, 5);
        step();
        bif.in_valid    = 1'b0;
        bif.dataB_enOut = 1'b0;
        chk("byp_count", count, 0);
`endif

        step();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
